// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises raw sources, latches edge- or level-mode
// pending bits, masks them toward the CPU and exposes MASK/MODE/PEND/ID registers.
module irq_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            sel,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic            ack,
  input  logic [2:0]      ack_id,
  output logic [NSRC-1:0] hwint,
  output logic            irq
);

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_MODE = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;
  localparam logic [1:0] A_ID   = 2'd3;

  logic [NSRC-1:0] s1, s2, s3;
  logic [NSRC-1:0] pend, mask, mode;
  logic [NSRC-1:0] edge_set, ack_clr, wr_clr, mode_chg, pend_nx;
  logic            wr_mask, wr_mode, wr_pend;
  logic [2:0]      id;
  logic            unused_wdata;

  // Lowest index wins, so scan from the top and let lower hits overwrite.
  function automatic logic [2:0] lowest_set(input logic [NSRC-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

  assign unused_wdata = ^wdata[31:NSRC];

  // Synchroniser stage: s1/s2 resolve metastability, s3 remembers s2 for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pending stage: set beats clear so an edge coinciding with a clear is not lost
  always_comb begin
    wr_mask  = sel && we && (addr == A_MASK);
    wr_mode  = sel && we && (addr == A_MODE);
    wr_pend  = sel && we && (addr == A_PEND);
    edge_set = mode & s2 & ~s3;
    wr_clr   = wr_pend ? wdata[NSRC-1:0] : '0;
    mode_chg = wr_mode ? (wdata[NSRC-1:0] ^ mode) : '0;
    ack_clr  = '0;
    for (int i = 0; i < NSRC; i++)
      if (ack && (int'(ack_id) == i)) ack_clr[i] = 1'b1;
    pend_nx  = ((mode & (edge_set | (pend & ~(ack_clr | wr_clr)))) | (~mode & s2))
               & ~mode_chg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
      mask <= '0;
      mode <= '0;
    end else begin
      pend <= pend_nx;
      if (wr_mask) mask <= wdata[NSRC-1:0];
      if (wr_mode) mode <= wdata[NSRC-1:0];
    end
  end

  // Output stage: combinational mask, priority encode and register read mux
  assign hwint = pend & mask;
  assign irq   = |hwint;
  assign id    = lowest_set(hwint);

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        A_MASK:  rdata[NSRC-1:0] = mask;
        A_MODE:  rdata[NSRC-1:0] = mode;
        A_PEND:  rdata[NSRC-1:0] = pend;
        A_ID:    rdata = {irq, 28'b0, id};
        default: rdata = '0;
      endcase
    end
  end

endmodule
